// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins: row drive out to the pad, column sense back, plus the decoded key code.
// The master side is the scanner; the slave side is the keypad/consumer.
interface keypad_scanner_if;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [7:0] key_val;

    modport master (
        input  col_in,
        output row_out,
        output key_val
    );

    modport slave (
        output col_in,
        input  row_out,
        input  key_val
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-hot row drive, two-flop column synchroniser, registered one-hot {row,col} code.
// Latency: column change reaches key_val after 3 edges while holding; no backpressure, no debounce.
module keypad_scanner #(
    parameter int SCAN_DIV = 48000,
    parameter int CNT_W    = 16
) (
    input  logic               int_osc,
    input  logic               reset,
    keypad_scanner_if.master   kp
);

    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       row_q;
    logic [7:0]       key_q;
    logic [3:0]       c_meta_q;
    logic [3:0]       c_sync_q;

    logic [3:0]       pri_col_d;
    logic [3:0]       row_rot_d;
    logic             col_hit_d;

    // Isolate the lowest set column so the col field is never multi-hot.
    always_comb begin
        pri_col_d = c_sync_q & (~c_sync_q + 4'd1);
        row_rot_d = {row_q[2:0], row_q[3]};
        col_hit_d = (c_sync_q != 4'd0);
    end

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            state_q  <= SCAN;
            cnt_q    <= '0;
            row_q    <= 4'b0001;
            key_q    <= 8'h00;
            c_meta_q <= 4'd0;
            c_sync_q <= 4'd0;
        end else begin
            c_meta_q <= kp.col_in;
            c_sync_q <= c_meta_q;

            case (state_q)
                SCAN: begin
                    key_q <= 8'h00;
                    // Sampling only at the end of the dwell lets the new row settle through both sync flops.
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (col_hit_d) begin
                            state_q <= HOLD;
                            key_q   <= {row_q, pri_col_d};
                        end else begin
                            row_q <= row_rot_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                HOLD: begin
                    cnt_q <= '0;
                    if (col_hit_d) begin
                        key_q <= {row_q, pri_col_d};
                    end else begin
                        key_q   <= 8'h00;
                        row_q   <= row_rot_d;
                        state_q <= SCAN;
                    end
                end

                default: begin
                    state_q <= SCAN;
                    cnt_q   <= '0;
                    key_q   <= 8'h00;
                end
            endcase
        end
    end

    assign kp.row_out = row_q;
    assign kp.key_val = key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus pushes expected key codes, a negedge monitor pops on each key_val change.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int CNT_W    = 3;
    localparam int BUDGET   = 40;

    logic int_osc = 1'b0;
    logic reset   = 1'b0;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .int_osc (int_osc),
        .reset   (reset),
        .kp      (kp.master)
    );

    always #5 int_osc = ~int_osc;

    // Keypad model: pressed[r*4+c] closes the switch between row r and column c.
    logic [15:0] pressed = 16'h0000;
    logic [3:0]  col_v;

    always_comb begin
        col_v = 4'd0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (kp.row_out[r] && pressed[r*4 + c]) col_v[c] = 1'b1;
    end
    assign kp.col_in = col_v;

    logic [7:0] exp_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] prev_kv = 8'h00;

    // Reference: the held key is reported as its row one-hot and the lowest pressed column one-hot.
    function automatic logic [7:0] key_code(input int row, input logic [3:0] mask);
        logic [3:0] rf;
        logic [3:0] cf;
        rf = 4'(1 << row);
        cf = 4'd0;
        for (int i = 3; i >= 0; i--)
            if (mask[i]) cf = 4'(1 << i);
        return {rf, cf};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge int_osc);
        #1;
    endtask

    task automatic drain(input int budget, input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(posedge int_osc);
            i++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: %0d expected codes still outstanding after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
        #1;
    endtask

    always @(negedge int_osc) begin
        if (kp.key_val !== prev_kv) begin
            if (!reset) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected: key_val changed to %h, expected no change at %0t",
                             kp.key_val, $time);
                end else begin
                    check("sb_key_val", kp.key_val, exp_q.pop_front());
                end
            end
            prev_kv = kp.key_val;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_row;
        logic [7:0] cur;
        logic [7:0] nxt;
        logic [3:0] m;
        logic [3:0] m2;
        logic [3:0] mo;
        int         r;
        int         o;
        bit         other;

        #1 reset = 1'b1;
        tick(2);
        check("rst_row", {4'd0, kp.row_out}, 8'h01);
        check("rst_key", kp.key_val, 8'h00);
        reset = 1'b0;

        // Idle scan: row advances every SCAN_DIV clocks, key stays clear.
        exp_row = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick(SCAN_DIV);
            exp_row = {exp_row[2:0], exp_row[3]};
            check("idle_row", {4'd0, kp.row_out}, {4'd0, exp_row});
            check("idle_key", kp.key_val, 8'h00);
        end

        // Press r0c0, expect detection within 4*SCAN_DIV+1 edges and a frozen row.
        exp_q.push_back(8'h11);
        pressed[0] = 1'b1;
        drain(4*SCAN_DIV + 2, "t2_detect");
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check("t2_row_frozen", {4'd0, kp.row_out}, 8'h01);
            check("t2_key_held", kp.key_val, 8'h11);
        end

        // Release: key clears on the third edge together with the row rotation.
        pressed[0] = 1'b0;
        exp_q.push_back(8'h00);
        tick(2);
        check("t3_key_before", kp.key_val, 8'h11);
        tick(1);
        check("t3_key_clear", kp.key_val, 8'h00);
        check("t3_row_next", {4'd0, kp.row_out}, 8'h02);
        drain(5, "t3_drain");

        // Hold r3c3, add r1c0 (invisible), then release r3c3.
        exp_q.push_back(8'h88);
        pressed[15] = 1'b1;
        drain(BUDGET, "t4_detect");
        pressed[4] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check("t4_key_masked", kp.key_val, 8'h88);
        end
        pressed[15] = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h21);
        drain(20, "t4_second_key");
        pressed[4] = 1'b0;
        exp_q.push_back(8'h00);
        drain(BUDGET, "t4_release");

        // Two keys on one row: lowest column wins.
        exp_q.push_back(8'h42);
        pressed[9]  = 1'b1;
        pressed[11] = 1'b1;
        drain(BUDGET, "t5_detect");
        pressed[9]  = 1'b0;
        pressed[11] = 1'b0;
        exp_q.push_back(8'h00);
        drain(BUDGET, "t5_release");

        // Reset mid-hold clears outputs immediately; key is found again afterwards.
        exp_q.push_back(8'h24);
        pressed[6] = 1'b1;
        drain(BUDGET, "t6_detect");
        @(posedge int_osc);
        #2 reset = 1'b1;
        #1;
        check("t6_async_key", kp.key_val, 8'h00);
        check("t6_async_row", {4'd0, kp.row_out}, 8'h01);
        tick(2);
        reset = 1'b0;
        exp_q.push_back(8'h24);
        drain(BUDGET, "t6_redetect");
        check("t6_row_after", {4'd0, kp.row_out}, 8'h02);
        pressed[6] = 1'b0;
        exp_q.push_back(8'h00);
        drain(BUDGET, "t6_release");

        // Randomised holds with same-row changes and masked keys on other rows.
        for (int it = 0; it < 30; it++) begin
            r   = $urandom_range(0, 3);
            m   = 4'($urandom_range(1, 15));
            cur = key_code(r, m);
            exp_q.push_back(cur);
            pressed[r*4 +: 4] = m;
            drain(BUDGET, "rnd_detect");
            for (int k = 0; k < 3; k++) begin
                tick(1);
                check("rnd_row_frozen", {4'd0, kp.row_out}, {4'd0, 4'(1 << r)});
            end

            if ($urandom_range(0, 1) == 1) begin
                m2  = 4'($urandom_range(1, 15));
                nxt = key_code(r, m2);
                if (nxt != cur) exp_q.push_back(nxt);
                cur = nxt;
                pressed[r*4 +: 4] = m2;
                drain(10, "rnd_same_row");
                tick(3);
                check("rnd_same_row_key", kp.key_val, cur);
            end

            other = ($urandom_range(0, 1) == 1);
            o     = (r + int'($urandom_range(1, 3))) % 4;
            mo    = 4'($urandom_range(1, 15));
            if (other) begin
                pressed[o*4 +: 4] = mo;
                tick(6);
                check("rnd_other_masked", kp.key_val, cur);
            end

            pressed[r*4 +: 4] = 4'd0;
            exp_q.push_back(8'h00);
            if (other) exp_q.push_back(key_code(o, mo));
            drain(BUDGET, "rnd_release");
            if (other) begin
                pressed[o*4 +: 4] = 4'd0;
                exp_q.push_back(8'h00);
                drain(BUDGET, "rnd_other_release");
            end
            tick($urandom_range(1, 12));
        end

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
